// File: rtl/dlatch_write_sched_if.sv
// Requester / latch-bank bundle for dlatch_write_sched; slave = scheduler, master = requester side.
// Handshake: a requester raises req with addr/data and holds them until its one-cycle ack; values are captured at grant.
interface dlatch_write_sched_if #(
   parameter int NUM_REQ   = 2,
   parameter int NUM_LATCH = 8
);
   localparam int AW = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1;

   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ-1:0]    req_data;
   logic [NUM_REQ-1:0]    ack;
   logic                  busy;
   logic                  latch_d;
   logic [NUM_LATCH-1:0]  latch_g;

   modport slave (
      input  req, req_addr, req_data,
      output ack, busy, latch_d, latch_g
   );

   modport master (
      output req, req_addr, req_data,
      input  ack, busy, latch_d, latch_g
   );
endinterface

// File: rtl/dlatch_write_sched.sv
// Arbitrated setup -> gate -> hold write sequencer for a D-latch bank; all bank-facing outputs registered.
// Define DLATCH_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module dlatch_write_sched #(
   parameter int NUM_REQ     = 2,
   parameter int NUM_LATCH   = 8,
   parameter int GATE_CYCLES = 2,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   dlatch_write_sched_if.slave sched_if,
   output logic [2:0]          dbg_state_o
);
   localparam int AW   = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1;
   localparam int IW   = $clog2(NUM_REQ);
   localparam int MAXC = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
   localparam logic [AW:0]   NL        = (AW+1)'(NUM_LATCH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_GATE  = 3'd2,
      S_HOLD  = 3'd3,
      S_ACK   = 3'd4
   } state_t;

   state_t               state_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic                 busy_q;
   logic                 latch_d_q;
   logic [NUM_LATCH-1:0] latch_g_q;
   logic [CW-1:0]        cnt_q;
   logic [IW-1:0]        id_q;
   logic [AW-1:0]        addr_q;
   logic [IW-1:0]        win_d;
   logic [NUM_LATCH-1:0] gate_d;

`ifdef DLATCH_SCHED_FIXED_PRIO_EN
   always_comb begin
      win_d = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (sched_if.req[i]) win_d = IW'(i);
      end
   end
`else
   logic [IW-1:0] ptr_q;

   // Walk downwards so the requester closest after the pointer is the last (winning) assignment.
   always_comb begin
      win_d = ptr_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (sched_if.req[(int'(ptr_q) + k) % NUM_REQ]) win_d = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= IW'(NUM_REQ - 1);
      end else if (state_q == S_IDLE && |sched_if.req) begin
         ptr_q <= win_d;
      end
   end
`endif

   // Out-of-range addresses (non-power-of-2 bank) gate nothing but still run the full sequence.
   always_comb begin
      gate_d = '0;
      if ({1'b0, addr_q} < NL) gate_d[addr_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ack_q     <= '0;
         busy_q    <= 1'b0;
         latch_d_q <= 1'b0;
         latch_g_q <= '0;
         cnt_q     <= '0;
         id_q      <= '0;
         addr_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|sched_if.req) begin
                  id_q      <= win_d;
                  addr_q    <= sched_if.req_addr[win_d*AW +: AW];
                  latch_d_q <= sched_if.req_data[win_d];
                  busy_q    <= 1'b1;
                  state_q   <= S_SETUP;
               end
            end
            S_SETUP: begin
               latch_g_q <= gate_d;
               cnt_q     <= GATE_LOAD;
               state_q   <= S_GATE;
            end
            S_GATE: begin
               if (cnt_q == '0) begin
                  latch_g_q <= '0;
                  cnt_q     <= HOLD_LOAD;
                  state_q   <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            // Hold runs one cycle past HOLD_CYCLES, so ack lands 3+GATE+HOLD cycles after grant.
            S_HOLD: begin
               if (cnt_q == '0) begin
                  ack_q       <= '0;
                  ack_q[id_q] <= 1'b1;
                  state_q     <= S_ACK;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_ACK: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q   <= S_IDLE;
               ack_q     <= '0;
               busy_q    <= 1'b0;
               latch_g_q <= '0;
            end
         endcase
      end
   end

   assign sched_if.ack     = ack_q;
   assign sched_if.busy    = busy_q;
   assign sched_if.latch_d = latch_d_q;
   assign sched_if.latch_g = latch_g_q;
   assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_dlatch_write_sched.sv
// Bench for dlatch_write_sched: directed write/arbitration/reset sequences plus random
// multi-requester traffic, checked against a timeline model and an ack scoreboard.
`timescale 1ns/1ps
module tb_dlatch_write_sched;
   localparam int NUM_REQ   = 2;
   localparam int NUM_LATCH = 8;
   localparam int G         = 2;
   localparam int H         = 1;
   localparam int AW        = $clog2(NUM_LATCH);
   localparam int W         = 49;   // {ack edge count[48:17], id[16:9], addr[8:1], data[0]}

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] dbg_state;

   dlatch_write_sched_if #(.NUM_REQ(NUM_REQ), .NUM_LATCH(NUM_LATCH)) bus ();

   dlatch_write_sched #(
      .NUM_REQ(NUM_REQ), .NUM_LATCH(NUM_LATCH), .GATE_CYCLES(G), .HOLD_CYCLES(H)
   ) dut (
      .clk(clk), .rst(rst), .sched_if(bus), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];
   bit           mon_en   = 1'b0;
   int           edge_cnt = 0;
   int           mdl_last = NUM_REQ - 1;
   int           mdl_next_free = 0;
   int           mdl_from = -100;
   int           mdl_addr = 0;
   logic         mdl_d    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Reference model: a write granted at edge e owns the bus until edge e+3+G+H; the
   // next request is sampled at e+4+G+H. Arbitration picks from the levels seen at the edge.
   initial forever begin
      int e;
      int win;
      @(posedge clk);
      e = edge_cnt;
      if (rst) begin
         exp_q.delete();
         mdl_last      = NUM_REQ - 1;
         mdl_d         = 1'b0;
         mdl_from      = -100;
         mdl_next_free = e + 1;
      end else if (e >= mdl_next_free && bus.req != '0) begin
         win = -1;
`ifdef DLATCH_SCHED_FIXED_PRIO_EN
         for (int i = 0; i < NUM_REQ; i++) if (win < 0 && bus.req[i]) win = i;
`else
         for (int k = 1; k <= NUM_REQ; k++)
            if (win < 0 && bus.req[(mdl_last + k) % NUM_REQ]) win = (mdl_last + k) % NUM_REQ;
`endif
         mdl_from      = e;
         mdl_addr      = int'(bus.req_addr[win*AW +: AW]);
         mdl_d         = bus.req_data[win];
         mdl_last      = win;
         mdl_next_free = e + 4 + G + H;
         exp_q.push_back({32'(e + 3 + G + H), 8'(win), 8'(mdl_addr), mdl_d});
      end
      edge_cnt = edge_cnt + 1;
   end

   // Monitor: per-cycle output timeline plus ack scoreboard.
   initial forever begin
      int                   e;
      logic [NUM_LATCH-1:0] exp_g;
      logic [W-1:0]         item;
      @(negedge clk);
      if (mon_en) begin
         e     = edge_cnt - 1;
         exp_g = '0;
         if (e >= mdl_from + 1 && e <= mdl_from + G && mdl_addr < NUM_LATCH) exp_g[mdl_addr] = 1'b1;
         check("busy", bus.busy, (e >= mdl_from && e <= mdl_from + 2 + G + H));
         check("latch_g", bus.latch_g, exp_g);
         check("latch_d", bus.latch_d, mdl_d);
         check("latch_g_onehot0", ($countones(bus.latch_g) <= 1), 1);
         if (bus.ack != '0) begin
            if (exp_q.size() == 0) begin
               check("ack_unexpected", bus.ack, 0);
            end else begin
               item = exp_q.pop_front();
               check("ack_vector", bus.ack, 64'(1) << item[16:9]);
               check("ack_timing", edge_cnt, item[48:17]);
            end
         end else if (exp_q.size() != 0 && edge_cnt > int'(exp_q[0][48:17])) begin
            item = exp_q.pop_front();
            check("ack_missing", bus.ack, 64'(1) << item[16:9]);
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("wait_idle", bus.busy, 0);
   endtask

   initial begin
      int  prev;
      int  id;
      int  grants;
      int  t;
      bit  draining;
      bus.req      = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ack", bus.ack, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_latch_d", bus.latch_d, 0);
      check("reset_latch_g", bus.latch_g, 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single write to latch 5; addr/data scrambled right after grant must be ignored.
      @(negedge clk);
      bus.req[0]              = 1'b1;
      bus.req_addr[0 +: AW]   = AW'(5);
      bus.req_data[0]         = 1'b1;
      @(negedge clk);
      check("t2_setup_d", bus.latch_d, 1);
      check("t2_setup_g", bus.latch_g, 0);
      check("t2_setup_busy", bus.busy, 1);
      bus.req_addr[0 +: AW]   = AW'(2);
      bus.req_data[0]         = 1'b0;
      for (int j = 1; j <= G + H + 2; j++) begin
         @(negedge clk);
         if (j <= G) check("t2_gate", bus.latch_g, 8'h20);
         else        check("t2_hold_g", bus.latch_g, 0);
         check("t2_d", bus.latch_d, 1);
         if (j == G + H + 2) check("t2_ack", bus.ack, 2'b01);
         else                check("t2_no_ack", bus.ack, 0);
      end
      bus.req[0] = 1'b0;

      // Both requesters held high: grant order.
      wait_idle();
      bus.req  = '1;
      prev     = -1;
      grants   = 0;
      t        = 0;
      while (grants < 4 && t < 200) begin
         @(negedge clk);
         t++;
         if (bus.ack != '0) begin
            id = 0;
            for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i]) id = i;
`ifdef DLATCH_SCHED_FIXED_PRIO_EN
            check("t3_fixed_prio", id, 0);
`else
            if (prev >= 0) check("t3_rr_alternate", id, 1 - prev);
`endif
            prev = id;
            grants++;
         end
      end
      check("t3_grants", grants, 4);
      bus.req = '0;

      // Reset in the middle of a gate pulse discards the write; the held request is served afresh.
      wait_idle();
      bus.req[1]            = 1'b1;
      bus.req_addr[AW +: AW] = AW'(3);
      bus.req_data[1]       = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5_in_gate", bus.latch_g, 8'h08);
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_g", bus.latch_g, 0);
      check("t5_rst_d", bus.latch_d, 0);
      check("t5_rst_busy", bus.busy, 0);
      check("t5_rst_ack", bus.ack, 0);
      rst = 1'b0;
      t   = 0;
      while (bus.ack == '0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("t5_served", bus.ack, 2'b10);
      bus.req[1] = 1'b0;

      // Random traffic, then drain.
      draining = 1'b0;
      t        = 0;
      while (t < 2000) begin
         @(negedge clk);
         t++;
         if (t > 1500) draining = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.ack[i]) begin
               if (!draining && $urandom_range(0, 1) == 1) begin
                  bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, NUM_LATCH - 1));
                  bus.req_data[i]          = 1'($urandom_range(0, 1));
               end else begin
                  bus.req[i] = 1'b0;
               end
            end else if (!bus.req[i]) begin
               if (!draining && $urandom_range(0, 2) == 0) begin
                  bus.req[i]               = 1'b1;
                  bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, NUM_LATCH - 1));
                  bus.req_data[i]          = 1'($urandom_range(0, 1));
               end
            end else if ($urandom_range(0, 3) == 0) begin
               bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, NUM_LATCH - 1));
               bus.req_data[i]          = 1'($urandom_range(0, 1));
            end
         end
         if (draining && bus.req == '0 && !bus.busy && exp_q.size() == 0) break;
      end
      check("drain_req", bus.req, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
